mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL have port RESET, input, 1, synchronous active-high reset, sampled on the rising edge of CLK.
REQ-003 SHALL have port MemReadM, input, 1, the M-stage instruction is a load.
REQ-004 SHALL have port MemWriteM, input, 1, the M-stage instruction is a store.
REQ-005 SHALL have port Funct3M, input, 3, access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 SHALL have port ALUResultM, input, 32, byte address of the access.
REQ-007 SHALL have port WriteDataM, input, 32, store data, right-aligned.
REQ-008 SHALL have port DAck, input, 1, data memory completes the outstanding request this cycle.
REQ-009 SHALL have port DRData, input, 32, word read data, valid when DAck=1.
REQ-010 SHALL have port DReq, output, 1, request valid toward data memory.
REQ-011 SHALL have port DWe, output, 1, request is a write.
REQ-012 SHALL have port DAddr, output, 32, word address {ALUResultM[31:2],2'b00}.
REQ-013 SHALL have port DByteEn, output, 4, byte lanes written.
REQ-014 SHALL have port DWData, output, 32, lane-replicated store data.
REQ-015 SHALL have port ReadDataM, output, 32, aligned and extended load result, consumed by the M/W register.
REQ-016 SHALL have port StallM, output, 1, freezes F/D/E/M stages while an access is outstanding.
REQ-017 SHALL have port MisalignM, output, 1, one-cycle pulse flagging a misaligned access.
REQ-018 SHALL have port BusErrM, output, 1, one-cycle pulse flagging a watchdog timeout.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-020 IDLE, (MemReadM|MemWriteM) aligned: DReq=1, StallM=1, next WAIT; DReq held and address/data/byte-enables held stable until DAck.
REQ-021 WAIT: DReq=1, StallM=1; on DAck capture load data, next DONE; DAck in the same cycle as the IDLE request is also accepted, going directly to DONE.
REQ-022 DONE: DReq=0, StallM=0, ReadDataM driven from captured register for exactly this cycle; next IDLE, so back-to-back memory ops re-request on the following cycle.
REQ-023 Misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0): no DReq, StallM=0, MisalignM=1 for one cycle, ReadDataM=0, remain IDLE.
REQ-024 Store byte enables: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111; DWData replicates WriteDataM[7:0] x4 (B), [15:0] x2 (H), full word (W).
REQ-025 Load extraction: select byte/halfword by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-026 Loads: DWe=0, DByteEn=0000.
REQ-027 SHALL count WAIT cycles in an 8-bit watchdog; when the count reaches 255 without DAck, BusErrM=1 for one cycle, DReq drops, ReadDataM=0, StallM=0, next IDLE.
REQ-028 A DAck arriving in IDLE or DONE SHALL be ignored.
REQ-029 A non-memory instruction in IDLE: all D* outputs 0, StallM=0, ReadDataM=0.

Reset
REQ-030 RESET SHALL force IDLE, clear the watchdog and captured data; every output 0 the cycle after reset, including mid-WAIT abort (request abandoned, no BusErrM).
REQ-031 RESET SHALL dominate DAck in the same cycle.

Structure
REQ-032 Funct3 size encodings and FSM state encodings SHALL live in the shared core package.
REQ-033 Load alignment/extension SHALL be one combinational sub-module, load_align.

Verification
REQ-034 LW addr 0x100, DAck after 3 cycles, DRData 0xDEADBEEF -> StallM high 4 cycles, ReadDataM=0xDEADBEEF in DONE.
REQ-035 LB addr 0x103, DRData 0x80FFFFFF -> ReadDataM=0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 SH addr 0x202, WriteDataM 0x1234ABCD -> DByteEn=1100, DWData=0xABCDABCD, DWe=1.
REQ-037 LW addr 0x101 -> MisalignM one cycle, DReq never asserted, StallM=0.
REQ-038 LW with DAck never asserted -> BusErrM pulse after 255 WAIT cycles, StallM drops, FSM IDLE.
REQ-039 RESET asserted in WAIT, then DAck -> outputs 0, no capture, no BusErrM.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the M-stage data memory access unit: Funct3 size codes,
// FSM states and the store lane-placement helpers.
package mem_access_unit_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Funct3[1:0] alone selects the access size; bit 2 only selects zero-extension.
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } mau_state_e;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         SZ_B:    return 1'b0;
         SZ_H:    return off[0];
         default: return off != 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] store_byte_en(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         SZ_B:    return 4'b0001 << off;
         SZ_H:    return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] data);
      case (funct3[1:0])
         SZ_B:    return {4{data[7:0]}};
         SZ_H:    return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte/halfword out of a memory word and sign- or
// zero-extends it according to Funct3.
module load_align
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] word,
   output logic [31:0] data
);

   logic [31:0] shifted;

   always_comb begin
      shifted = word >> {byte_off, 3'b000};
      case (funct3)
         F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   data = {24'd0, shifted[7:0]};
         F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   data = {16'd0, shifted[15:0]};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data memory access unit: issues one request per load/store, stalls the
// pipeline until DAck, aligns load data, and flags misalignment and bus timeouts.
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic        DAck,
   input  logic [31:0] DRData,
   output logic        DReq,
   output logic        DWe,
   output logic [31:0] DAddr,
   output logic [3:0]  DByteEn,
   output logic [31:0] DWData,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        MisalignM,
   output logic        BusErrM
);

   // Handshake: DReq stays high with address/data/byte-enables frozen from the
   // issuing cycle until the first cycle DAck=1; DAck outside a request is ignored.

   mau_state_e  state_q, state_d;
   logic [7:0]  wd_q;
   logic [29:0] addr_q;
   logic [1:0]  off_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic [2:0]  f3_q;
   logic [31:0] rdata_q;

   logic        mem_op, mis, new_req, capture;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic [29:0] cur_addr;
   logic [1:0]  cur_off;
   logic        cur_we;
   logic [3:0]  cur_be;
   logic [31:0] cur_wdata;
   logic [2:0]  cur_f3;
   logic [31:0] aligned;

   assign mem_op    = MemReadM | MemWriteM;
   assign mis       = is_misaligned(Funct3M, ALUResultM[1:0]);
   assign new_req   = (state_q == IDLE) && mem_op && !mis;
   assign req_be    = MemWriteM ? store_byte_en(Funct3M, ALUResultM[1:0]) : 4'b0000;
   assign req_wdata = MemWriteM ? store_data(Funct3M, WriteDataM) : 32'd0;

   // The issuing cycle drives straight from the inputs; WAIT replays the held copy.
   always_comb begin
      if (state_q == WAIT) begin
         cur_addr  = addr_q;
         cur_off   = off_q;
         cur_we    = we_q;
         cur_be    = be_q;
         cur_wdata = wdata_q;
         cur_f3    = f3_q;
      end else begin
         cur_addr  = ALUResultM[31:2];
         cur_off   = ALUResultM[1:0];
         cur_we    = MemWriteM;
         cur_be    = req_be;
         cur_wdata = req_wdata;
         cur_f3    = Funct3M;
      end
   end

   load_align u_load_align (
      .funct3   (cur_f3),
      .byte_off (cur_off),
      .word     (DRData),
      .data     (aligned)
   );

   always_comb begin
      state_d   = state_q;
      capture   = 1'b0;
      DReq      = 1'b0;
      DWe       = 1'b0;
      DAddr     = 32'd0;
      DByteEn   = 4'b0000;
      DWData    = 32'd0;
      ReadDataM = 32'd0;
      StallM    = 1'b0;
      MisalignM = 1'b0;
      BusErrM   = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op && mis) begin
               MisalignM = 1'b1;
            end else if (mem_op) begin
               DReq    = 1'b1;
               DWe     = cur_we;
               DAddr   = {cur_addr, 2'b00};
               DByteEn = cur_be;
               DWData  = cur_wdata;
               StallM  = 1'b1;
               capture = DAck;
               state_d = DAck ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (wd_q == 8'hFF) begin
               BusErrM = 1'b1;
               state_d = IDLE;
            end else begin
               DReq    = 1'b1;
               DWe     = cur_we;
               DAddr   = {cur_addr, 2'b00};
               DByteEn = cur_be;
               DWData  = cur_wdata;
               StallM  = 1'b1;
               capture = DAck;
               if (DAck) state_d = DONE;
            end
         end
         DONE: begin
            ReadDataM = rdata_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (RESET) begin
         state_d   = IDLE;
         capture   = 1'b0;
         DReq      = 1'b0;
         DWe       = 1'b0;
         DAddr     = 32'd0;
         DByteEn   = 4'b0000;
         DWData    = 32'd0;
         ReadDataM = 32'd0;
         StallM    = 1'b0;
         MisalignM = 1'b0;
         BusErrM   = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         wd_q    <= 8'd0;
         addr_q  <= 30'd0;
         off_q   <= 2'b00;
         we_q    <= 1'b0;
         be_q    <= 4'b0000;
         wdata_q <= 32'd0;
         f3_q    <= 3'b000;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         // Watchdog counts consecutive WAIT cycles only.
         if (state_q == WAIT && state_d == WAIT) wd_q <= wd_q + 8'd1;
         else                                    wd_q <= 8'd0;
         if (new_req) begin
            addr_q  <= ALUResultM[31:2];
            off_q   <= ALUResultM[1:0];
            we_q    <= MemWriteM;
            be_q    <= req_be;
            wdata_q <= req_wdata;
            f3_q    <= Funct3M;
         end
         if (capture) rdata_q <= cur_we ? 32'd0 : aligned;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against a behavioural model
// of load extraction, store lane placement, stall timing and the watchdog.
module tb_mem_access_unit;

   logic        CLK;
   logic        RESET;
   logic        MemReadM, MemWriteM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM, WriteDataM;
   logic        DAck;
   logic [31:0] DRData;
   logic        DReq, DWe;
   logic [31:0] DAddr;
   logic [3:0]  DByteEn;
   logic [31:0] DWData, ReadDataM;
   logic        StallM, MisalignM, BusErrM;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q[$];

   mem_access_unit dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .Funct3M    (Funct3M),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .DAck       (DAck),
      .DRData     (DRData),
      .DReq       (DReq),
      .DWe        (DWe),
      .DAddr      (DAddr),
      .DByteEn    (DByteEn),
      .DWData     (DWData),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .MisalignM  (MisalignM),
      .BusErrM    (BusErrM)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] word);
      int unsigned off, b, h;
      off = addr % 4;
      b = (word >> (8 * off)) % 256;
      h = (word >> (8 * off)) % 65536;
      case (f3)
         3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
         3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return word;
      endcase
   endfunction

   function automatic logic m_misaligned(input logic [2:0] f3, input logic [31:0] addr);
      case (f3)
         3'b000, 3'b100: return 1'b0;
         3'b001, 3'b101: return (addr % 2) != 0;
         default:        return (addr % 4) != 0;
      endcase
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
      int unsigned off;
      off = addr % 4;
      case (f3)
         3'b000:  return 4'(1 << off);
         3'b001:  return 4'(3 << off);
         default: return 4'd15;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (f3)
         3'b000:  return (wd % 256) * 32'h01010101;
         3'b001:  return (wd % 65536) * 32'h00010001;
         default: return wd;
      endcase
   endfunction

   // ---------------- checkers ----------------
   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
         $error("check %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic idle_inputs();
      MemReadM   = 1'b0;
      MemWriteM  = 1'b0;
      Funct3M    = 3'b000;
      ALUResultM = 32'd0;
      WriteDataM = 32'd0;
      DAck       = 1'b0;
      DRData     = 32'd0;
   endtask

   // One cycle with no memory instruction; a stray DAck must change nothing.
   task automatic idle_check(input string tag);
      idle_inputs();
      DAck   = 1'($urandom_range(0, 1));
      DRData = $urandom;
      @(negedge CLK);
      check1({tag, "_dreq"}, DReq, 1'b0);
      check1({tag, "_dwe"}, DWe, 1'b0);
      check32({tag, "_daddr"}, DAddr, 32'd0);
      check32({tag, "_dbe"}, 32'(DByteEn), 32'd0);
      check32({tag, "_dwdata"}, DWData, 32'd0);
      check32({tag, "_rdata"}, ReadDataM, 32'd0);
      check1({tag, "_stall"}, StallM, 1'b0);
      check1({tag, "_misalign"}, MisalignM, 1'b0);
      check1({tag, "_buserr"}, BusErrM, 1'b0);
      @(posedge CLK); #1;
      DAck = 1'b0;
   endtask

   // Issue one access; DAck arrives `delay` cycles after the issuing cycle
   // (delay > 255 means never, exercising the watchdog).
   task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rword, input int delay,
                            output logic [31:0] o_rdata, output int o_stall,
                            output logic [3:0] o_be, output logic [31:0] o_wdata);
      logic [31:0] exp_rd;
      o_rdata = 32'd0;
      o_stall = 0;
      o_be    = 4'd0;
      o_wdata = 32'd0;
      MemReadM   = rd;
      MemWriteM  = wr;
      Funct3M    = f3;
      ALUResultM = addr;
      WriteDataM = wd;
      if (m_misaligned(f3, addr)) begin
         DAck   = 1'($urandom_range(0, 1));
         DRData = $urandom;
         @(negedge CLK);
         check1("mis_pulse", MisalignM, 1'b1);
         check1("mis_dreq", DReq, 1'b0);
         check1("mis_stall", StallM, 1'b0);
         check32("mis_rdata", ReadDataM, 32'd0);
         @(posedge CLK); #1;
         idle_inputs();
         return;
      end
      if (rd) exp_q.push_back(m_load(f3, addr, rword));
      for (int c = 0; c <= 256; c++) begin
         DAck   = (c == delay);
         DRData = (c == delay) ? rword : $urandom;
         if (c > 0) begin
            ALUResultM = $urandom;
            WriteDataM = $urandom;
         end
         @(negedge CLK);
         if (c == 256) begin
            check1("to_buserr", BusErrM, 1'b1);
            check1("to_dreq", DReq, 1'b0);
            check1("to_stall", StallM, 1'b0);
            check32("to_rdata", ReadDataM, 32'd0);
            if (rd) exp_rd = exp_q.pop_front();
            @(posedge CLK); #1;
            idle_inputs();
            return;
         end
         if (StallM === 1'b1) o_stall++;
         if (c == 0) begin
            o_be    = DByteEn;
            o_wdata = DWData;
         end
         check1("req_dreq", DReq, 1'b1);
         check1("req_stall", StallM, 1'b1);
         check1("req_dwe", DWe, wr);
         check32("req_daddr", DAddr, addr & 32'hFFFFFFFC);
         check32("req_dbe", 32'(DByteEn), wr ? 32'(m_be(f3, addr)) : 32'd0);
         if (wr) check32("req_dwdata", DWData, m_wdata(f3, wd));
         check1("req_buserr", BusErrM, 1'b0);
         check32("req_rdata", ReadDataM, 32'd0);
         @(posedge CLK); #1;
         if (c == delay) begin
            idle_inputs();
            DAck   = 1'($urandom_range(0, 1));
            DRData = $urandom;
            @(negedge CLK);
            check1("done_dreq", DReq, 1'b0);
            check1("done_stall", StallM, 1'b0);
            check1("done_buserr", BusErrM, 1'b0);
            o_rdata = ReadDataM;
            if (rd) begin
               exp_rd = exp_q.pop_front();
               check32("done_rdata", ReadDataM, exp_rd);
            end
            @(posedge CLK); #1;
            DAck = 1'b0;
            return;
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] r, wdat;
      logic [3:0]  be;
      int          st;
      logic [2:0]  ld_f3 [5];
      logic [2:0]  f3;
      logic [31:0] addr;
      logic        rd;

      ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      idle_inputs();
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      idle_check("reset");

      // LW with DAck three cycles after the request
      do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 3, r, st, be, wdat);
      check32("lw_data", r, 32'hDEADBEEF);
      check32("lw_stall_cycles", 32'(st), 32'd4);
      idle_check("after_lw");

      // LB / LBU from the top byte
      do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FFFFFF, 1, r, st, be, wdat);
      check32("lb_data", r, 32'hFFFFFF80);
      do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FFFFFF, 0, r, st, be, wdat);
      check32("lbu_data", r, 32'h00000080);
      check32("lbu_stall_cycles", 32'(st), 32'd1);

      // SH to the upper half
      do_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'd0, 2, r, st, be, wdat);
      check32("sh_be", 32'(be), 32'h0000000C);
      check32("sh_wdata", wdat, 32'hABCDABCD);

      // misaligned LW
      do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 32'd0, 0, r, st, be, wdat);
      check32("mis_stall_cycles", 32'(st), 32'd0);
      idle_check("after_mis");

      // watchdog timeout, then an immediate new request proves return to IDLE
      do_access(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 32'd0, 1000, r, st, be, wdat);
      check32("to_stall_cycles", 32'(st), 32'd256);
      do_access(1'b1, 1'b0, 3'b101, 32'h402, 32'd0, 32'h9876FEDC, 0, r, st, be, wdat);
      check32("lhu_after_to", r, 32'h00009876);

      // reset in WAIT coinciding with DAck
      MemReadM   = 1'b1;
      Funct3M    = 3'b010;
      ALUResultM = 32'h300;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RESET  = 1'b1;
      DAck   = 1'b1;
      DRData = 32'hCAFEF00D;
      @(posedge CLK); #1;
      RESET = 1'b0;
      idle_check("post_reset_1");
      idle_check("post_reset_2");

      // randomized mix of loads, stores and idle cycles
      for (int i = 0; i < 60; i++) begin
         rd = 1'($urandom_range(0, 1));
         f3 = rd ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
         addr = $urandom;
         do_access(rd, !rd, f3, addr, $urandom, $urandom, $urandom_range(0, 5), r, st, be, wdat);
         if ($urandom_range(0, 3) == 0) idle_check("rand_idle");
      end

      check32("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
